hub75_row_driver: RTL and testbench

Downstream stage of the LED display pattern generator. It accepts one `rgb_row_t` row pair plus its 4-bit row address over a ready/valid handshake and serialises the pixels onto a HUB75 panel interface: shift clock, six colour lines, latch, output enable and row address. The shift of the next row overlaps the display time of the previous row, so the panel is blanked only for the blank/latch window.

---
 rtl/hub75_row_driver.sv | 205 ++++++++++++++++++++
 tb/tb_hub75_row_driver.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_row_driver.sv
// HUB75 row driver: accepts one row pair over ready/valid, shifts it out on the panel
// shift clock while the previous row is still displayed, then blanks, latches and enables.
`timescale 1ns/1ps

package gl_pkg;
    localparam int unsigned GL_NUM_COL_PIXELS = 32;
    localparam int unsigned GL_RGB_ROW_W      = 6 * GL_NUM_COL_PIXELS;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_t;

    typedef struct packed {
        rgb_t top;
        rgb_t bot;
    } rgb_row_t;
endpackage

module hub75_row_driver
    import gl_pkg::*;
#(
    parameter int unsigned SCLK_DIV       = 2,
    parameter int unsigned DISPLAY_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES   = 4
) (
    input  logic       clk_in,
    input  logic       n_reset_in,
    input  rgb_row_t   row_in,
    input  logic       row_valid_in,
    output logic       row_ready_out,
    input  logic [3:0] row_address_in,
    output logic       hub_r0_out,
    output logic       hub_g0_out,
    output logic       hub_b0_out,
    output logic       hub_r1_out,
    output logic       hub_g1_out,
    output logic       hub_b1_out,
    output logic       hub_sclk_out,
    output logic       hub_lat_out,
    output logic       hub_oe_n_out,
    output logic [3:0] hub_addr_out,
    output logic       frame_start_out
);

    localparam int unsigned COL_W = (GL_NUM_COL_PIXELS > 1) ? $clog2(GL_NUM_COL_PIXELS) : 1;
    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int unsigned DSP_W = $clog2(DISPLAY_CYCLES + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(GL_NUM_COL_PIXELS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);
    localparam logic [DSP_W-1:0] DSP_LOAD = DSP_W'(DISPLAY_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_BLANK,
        ST_LATCH
    } state_t;

    state_t           state_q, state_d;
    rgb_row_t         row_q, row_d;
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       addr_q, addr_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [DSP_W-1:0] disp_q, disp_d;
    logic [5:0]       rgb_q, rgb_d;
    logic             sclk_q, sclk_d;
    logic             lat_q, lat_d;
    logic             ready_q, ready_d;
    logic             fs_q, fs_d;

    // Colour bits of one column, ordered r0 g0 b0 r1 g1 b1.
    function automatic logic [5:0] column_bits(input rgb_row_t r, input logic [COL_W-1:0] c);
        return {r.top.red[c], r.top.green[c], r.top.blue[c],
                r.bot.red[c], r.bot.green[c], r.bot.blue[c]};
    endfunction

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        col_d   = col_q;
        div_d   = div_q;
        blk_d   = blk_q;
        rgb_d   = rgb_q;
        sclk_d  = sclk_q;
        lat_d   = lat_q;
        fs_d    = 1'b0;
        disp_d  = (disp_q != '0) ? disp_q - DSP_W'(1) : disp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (row_valid_in && ready_q) begin
                    row_d   = row_in;
                    pend_d  = row_address_in;
                    col_d   = COL_LAST;
                    rgb_d   = column_bits(row_in, COL_LAST);
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (col_q == '0) begin
                            state_d = ST_WAIT;
                        end else begin
                            col_d = col_q - COL_W'(1);
                            rgb_d = column_bits(row_q, col_q - COL_W'(1));
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_WAIT: begin
                // The new row may not be latched until the previous one has had its full display time.
                if (disp_q == '0) begin
                    addr_d  = pend_q;
                    blk_d   = '0;
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (blk_q == BLK_LAST) begin
                    lat_d   = 1'b1;
                    div_d   = '0;
                    state_d = ST_LATCH;
                end else begin
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            ST_LATCH: begin
                if (div_q == DIV_LAST) begin
                    lat_d   = 1'b0;
                    disp_d  = DSP_LOAD;
                    fs_d    = (addr_q == 4'd0);
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            pend_q  <= '0;
            addr_q  <= '0;
            col_q   <= '0;
            div_q   <= '0;
            blk_q   <= '0;
            disp_q  <= '0;
            rgb_q   <= '0;
            sclk_q  <= 1'b0;
            lat_q   <= 1'b0;
            ready_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            div_q   <= div_d;
            blk_q   <= blk_d;
            disp_q  <= disp_d;
            rgb_q   <= rgb_d;
            sclk_q  <= sclk_d;
            lat_q   <= lat_d;
            ready_q <= ready_d;
            fs_q    <= fs_d;
        end
    end

    assign row_ready_out   = ready_q;
    assign {hub_r0_out, hub_g0_out, hub_b0_out,
            hub_r1_out, hub_g1_out, hub_b1_out} = rgb_q;
    assign hub_sclk_out    = sclk_q;
    assign hub_lat_out     = lat_q;
    assign hub_addr_out    = addr_q;
    assign frame_start_out = fs_q;
    assign hub_oe_n_out    = (disp_q == '0) || (state_q == ST_BLANK) || (state_q == ST_LATCH);

endmodule

// File: tb/tb_hub75_row_driver.sv
// Bench for hub75_row_driver: a timeline model predicts every output each cycle,
// and directed measurements pin shift order, latency, latch width and display time.
`timescale 1ns/1ps

module tb_hub75_row_driver;
    import gl_pkg::*;

    localparam int SD        = 2;
    localparam int DC        = 1000;
    localparam int BC        = 4;
    localparam int NC        = GL_NUM_COL_PIXELS;
    localparam int SHIFT_CYC = NC * 2 * SD;

    logic       clk_in         = 1'b0;
    logic       n_reset_in     = 1'b0;
    rgb_row_t   row_in         = '0;
    logic       row_valid_in   = 1'b0;
    logic [3:0] row_address_in = 4'd0;
    logic       row_ready_out;
    logic       hub_r0_out, hub_g0_out, hub_b0_out;
    logic       hub_r1_out, hub_g1_out, hub_b1_out;
    logic       hub_sclk_out, hub_lat_out, hub_oe_n_out;
    logic [3:0] hub_addr_out;
    logic       frame_start_out;

    always #5 clk_in = ~clk_in;

    hub75_row_driver #(
        .SCLK_DIV      (SD),
        .DISPLAY_CYCLES(DC),
        .BLANK_CYCLES  (BC)
    ) dut (
        .clk_in         (clk_in),
        .n_reset_in     (n_reset_in),
        .row_in         (row_in),
        .row_valid_in   (row_valid_in),
        .row_ready_out  (row_ready_out),
        .row_address_in (row_address_in),
        .hub_r0_out     (hub_r0_out),
        .hub_g0_out     (hub_g0_out),
        .hub_b0_out     (hub_b0_out),
        .hub_r1_out     (hub_r1_out),
        .hub_g1_out     (hub_g1_out),
        .hub_b1_out     (hub_b1_out),
        .hub_sclk_out   (hub_sclk_out),
        .hub_lat_out    (hub_lat_out),
        .hub_oe_n_out   (hub_oe_n_out),
        .hub_addr_out   (hub_addr_out),
        .frame_start_out(frame_start_out)
    );

    function automatic logic [5:0] colour(input rgb_row_t r, input int col);
        return {r.top.red[col], r.top.green[col], r.top.blue[col],
                r.bot.red[col], r.bot.green[col], r.bot.blue[col]};
    endfunction

    function automatic rgb_row_t make_row(input logic [31:0] s);
        rgb_row_t r;
        r.top.red   = s;
        r.top.green = ~s;
        r.top.blue  = {s[15:0], s[31:16]};
        r.bot.red   = s ^ 32'h5A5A_5A5A;
        r.bot.green = s + 32'd1;
        r.bot.blue  = {s[7:0], s[31:8]};
        return r;
    endfunction

    // Timeline model: a row accepted in cycle t0 shifts for SHIFT_CYC cycles, then blanks
    // from the cycle after both its shift is done and the previous display time has run out.
    int         cyc        = 0;
    logic       m_oor      = 1'b0;
    logic       m_live     = 1'b0;
    int         m_t0       = 0;
    int         m_b        = 0;
    int         m_i        = 0;
    int         m_disp_end = 0;
    int         m_fs_cyc   = -1;
    rgb_row_t   m_row      = '0;
    logic [3:0] m_pend     = 4'd0;
    logic [3:0] m_addr     = 4'd0;
    logic [5:0] m_hold     = 6'd0;

    always @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            m_oor      = 1'b0;
            m_live     = 1'b0;
            m_disp_end = 0;
            m_fs_cyc   = -1;
            m_addr     = 4'd0;
            m_hold     = 6'd0;
            cyc        = cyc + 1;
        end else begin
            if (m_oor && !m_live && row_valid_in) begin
                int w;
                m_live = 1'b1;
                m_t0   = cyc + 1;
                m_row  = row_in;
                m_pend = row_address_in;
                w      = m_t0 + SHIFT_CYC;
                m_b    = ((w > m_disp_end) ? w : m_disp_end) + 1;
                m_i    = m_b + BC + SD;
            end
            m_oor = 1'b1;
            cyc   = cyc + 1;
            if (m_live && cyc >= m_i) begin
                m_live     = 1'b0;
                m_addr     = m_pend;
                m_disp_end = m_i + DC;
                m_hold     = colour(m_row, 0);
                if (m_pend == 4'd0) m_fs_cyc = m_i;
            end
        end
    end

    // Results measured by the stimulus process, checked at the end by the compare process.
    logic        done = 1'b0;
    int          to_cnt = 0;
    logic        rdy0, rdy1;
    int          busy1, rises1, b1z1, latc1, oe1;
    logic [31:0] seq1;
    logic [3:0]  lataddr1;
    int          busy2, rises2, b1z2, latc2, oe2;
    logic [31:0] seq2;
    logic [3:0]  lataddr2;
    int          busy3b, busy3c, fs_before, fs_after, lat_before, lat_after;
    int          busy5, rises5, b1z5, latc5;
    logic [31:0] seq5;
    logic [3:0]  lataddr5;

    int total     = 0;
    int bad       = 0;
    int lat_total = 0;
    int fs_total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_in) begin
        if (!done) begin
            logic       e_rdy, e_sclk, e_lat, e_oen, e_fs, blank;
            logic [3:0] e_addr;
            logic [5:0] e_rgb;
            int         k;
            if (!n_reset_in) begin
                e_rdy = 1'b0; e_sclk = 1'b0; e_lat = 1'b0; e_oen = 1'b1;
                e_fs = 1'b0; e_addr = 4'd0; e_rgb = 6'd0;
            end else begin
                e_rdy  = m_oor && !m_live;
                e_sclk = 1'b0;
                e_lat  = 1'b0;
                blank  = 1'b0;
                e_addr = m_addr;
                e_rgb  = m_hold;
                if (m_live) begin
                    k = cyc - m_t0;
                    if (k < SHIFT_CYC) begin
                        e_rgb  = colour(m_row, NC - 1 - k / (2 * SD));
                        e_sclk = (k % (2 * SD)) >= SD;
                    end else begin
                        e_rgb = colour(m_row, 0);
                    end
                    if (cyc >= m_b) begin
                        blank  = 1'b1;
                        e_addr = m_pend;
                    end
                    if (cyc >= m_b + BC) e_lat = 1'b1;
                end
                e_oen = (cyc >= m_disp_end) || blank;
                e_fs  = (cyc == m_fs_cyc);
            end
            chk("ready",   32'(row_ready_out), 32'(e_rdy));
            chk("sclk",    32'(hub_sclk_out),  32'(e_sclk));
            chk("lat",     32'(hub_lat_out),   32'(e_lat));
            chk("oe_n",    32'(hub_oe_n_out),  32'(e_oen));
            chk("addr",    32'(hub_addr_out),  32'(e_addr));
            chk("fstart",  32'(frame_start_out), 32'(e_fs));
            chk("colours", 32'({hub_r0_out, hub_g0_out, hub_b0_out,
                                hub_r1_out, hub_g1_out, hub_b1_out}), 32'(e_rgb));
            chk("lat_while_lit", 32'(hub_lat_out & ~hub_oe_n_out), 32'd0);
            if (hub_lat_out) lat_total = lat_total + 1;
            if (frame_start_out) fs_total = fs_total + 1;
        end else begin
            chk("send_timeout",   32'(to_cnt), 32'd0);
            chk("rst_ready_low",  32'(rdy0), 32'd0);
            chk("rst_ready_high", 32'(rdy1), 32'd1);
            chk("t1_busy",     32'(busy1),  32'd135);
            chk("t1_rises",    32'(rises1), 32'd32);
            chk("t1_r0_seq",   seq1,        32'hA5A5_A5A5);
            chk("t1_b1_low",   32'(b1z1),   32'd0);
            chk("t1_lat_len",  32'(latc1),  32'd2);
            chk("t1_lat_addr", 32'(lataddr1), 32'd5);
            chk("t1_oe_low",   32'(oe1),    32'd1000);
            chk("t2_busy",     32'(busy2),  32'd135);
            chk("t2_rises",    32'(rises2), 32'd32);
            chk("t2_r0_seq",   seq2,        32'h0F0F_1234);
            chk("t2_lat_len",  32'(latc2),  32'd2);
            chk("t2_lat_addr", 32'(lataddr2), 32'd3);
            chk("t2_oe_low",   32'(oe2),    32'd1000);
            chk("t3_busy_first",   32'(busy3b), 32'd135);
            chk("t3_busy_overlap", 32'(busy3c), 32'd1005);
            chk("t4_frame_pulses", 32'(fs_after - fs_before), 32'd1);
            chk("t5_no_latch_on_reset", 32'(lat_after - lat_before), 32'd0);
            chk("t5_busy",     32'(busy5),  32'd135);
            chk("t5_rises",    32'(rises5), 32'd32);
            chk("t5_r0_seq",   seq5,        32'h1234_5678);
            chk("t5_lat_len",  32'(latc5),  32'd2);
            chk("t5_lat_addr", 32'(lataddr5), 32'd11);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic send_row(input rgb_row_t r, input logic [3:0] a);
        int n;
        n = 0;
        step();
        row_in         = r;
        row_address_in = a;
        row_valid_in   = 1'b1;
        while (!row_ready_out && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) to_cnt++;
        step();
        row_valid_in = 1'b0;
    endtask

    task automatic measure_row(output int busy, output int rises, output logic [31:0] seq,
                               output int b1z, output int latc, output logic [3:0] lat_addr);
        logic prev;
        busy = 0; rises = 0; seq = '0; b1z = 0; latc = 0; lat_addr = 4'hF; prev = 1'b0;
        while (!row_ready_out && busy < 3000) begin
            if (hub_sclk_out && !prev) begin
                rises++;
                seq = {seq[30:0], hub_r0_out};
            end
            prev = hub_sclk_out;
            if (busy < SHIFT_CYC && !hub_b1_out) b1z++;
            if (hub_lat_out) begin
                latc++;
                lat_addr = hub_addr_out;
            end
            busy++;
            step();
        end
    endtask

    task automatic measure_oe(output int run);
        run = 0;
        while (!hub_oe_n_out && run < 2000) begin
            run++;
            step();
        end
    endtask

    initial begin
        rgb_row_t r;
        int       d0, d1, d2;
        logic [31:0] s0;
        logic [3:0]  a0;

        repeat (5) step();
        rdy0 = row_ready_out;
        n_reset_in = 1'b1;
        step();
        rdy1 = row_ready_out;

        r = '0;
        r.top.red  = 32'hA5A5_A5A5;
        r.bot.blue = '1;
        send_row(r, 4'd5);
        measure_row(busy1, rises1, seq1, b1z1, latc1, lataddr1);
        measure_oe(oe1);

        r = make_row(32'h0F0F_1234);
        r.bot.blue = '1;
        send_row(r, 4'd3);
        fork
            measure_row(busy2, rises2, seq2, b1z2, latc2, lataddr2);
            begin
                repeat (20) step();
                row_in         = make_row(32'hFFFF_0000);
                row_address_in = 4'd9;
                row_valid_in   = 1'b1;
                step();
                row_valid_in   = 1'b0;
            end
        join
        measure_oe(oe2);

        send_row(make_row(32'h0BAD_CAFE), 4'd7);
        measure_row(busy3b, d0, s0, d1, d2, a0);
        send_row(make_row(32'h3C3C_9696), 4'd8);
        measure_row(busy3c, d0, s0, d1, d2, a0);

        fs_before = fs_total;
        send_row(make_row(32'h0000_00E1), 4'd14);
        send_row(make_row(32'h0000_00F1), 4'd15);
        send_row(make_row(32'hF0F0_0001), 4'd0);
        send_row(make_row(32'h8001_7FFE), 4'd1);
        measure_row(d0, d1, s0, d2, d2, a0);
        step();
        fs_after = fs_total;
        measure_oe(d0);

        send_row(make_row(32'hCAFE_F00D), 4'd2);
        repeat (64) step();
        lat_before = lat_total;
        n_reset_in = 1'b0;
        repeat (5) step();
        n_reset_in = 1'b1;
        step();
        lat_after = lat_total;
        send_row(make_row(32'h1234_5678), 4'd11);
        measure_row(busy5, rises5, seq5, b1z5, latc5, lataddr5);
        repeat (3) step();

        done = 1'b1;
    end

endmodule
